// File: rtl/hls_array_server_if.sv
// rtl/hls_array_server_if.sv - host write, kernel read and status bundle for hls_array_server
interface hls_array_server_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_req_a;
    logic              rd_req_b;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              rd_valid_a;
    logic              rd_valid_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;

    logic              err_oob;
    logic              err_uninit;
    logic [31:0]       rd_cnt_a;
    logic [31:0]       rd_cnt_b;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data,
        output rd_req_a, rd_req_b, rd_addr_a, rd_addr_b,
        input  rd_valid_a, rd_valid_b, rd_data_a, rd_data_b,
        input  err_oob, err_uninit, rd_cnt_a, rd_cnt_b
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data,
        input  rd_req_a, rd_req_b, rd_addr_a, rd_addr_b,
        output rd_valid_a, rd_valid_b, rd_data_a, rd_data_b,
        output err_oob, err_uninit, rd_cnt_a, rd_cnt_b
    );
endinterface

// File: rtl/hls_array_server.sv
// rtl/hls_array_server.sv - two-array word store serving fixed-latency kernel reads
// Channel 0 reads array A, channel 1 reads array B; host writes either array.
module hls_array_server #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    hls_array_server_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W+1)'(DEPTH);
    endfunction

    logic [DATA_W-1:0] mem     [2][DEPTH];
    logic [DEPTH-1:0]  written [2];

    logic              req    [2];
    logic [ADDR_W-1:0] raddr  [2];
    logic              r_ok   [2];
    logic              r_hit  [2];
    logic [IDX_W-1:0]  r_idx  [2];
    logic [DATA_W-1:0] r_data [2];

    logic [RD_LAT-1:0] vld_q [2];
    logic [DATA_W-1:0] dat_q [2][RD_LAT];
    logic [31:0]       cnt_q [2];
    logic              err_oob_q;
    logic              err_uninit_q;

    logic              wr_ok;
    logic [IDX_W-1:0]  w_idx;
    logic              oob_hit;
    logic              uninit_hit;

    assign req[0]   = bus.rd_req_a;
    assign req[1]   = bus.rd_req_b;
    assign raddr[0] = bus.rd_addr_a;
    assign raddr[1] = bus.rd_addr_b;

    assign wr_ok = bus.wr_en && in_range(bus.wr_addr);
    assign w_idx = bus.wr_addr[IDX_W-1:0];

    // Lookup happens in the request cycle, so a same-cycle write is not yet visible.
    always_comb begin
        oob_hit    = bus.wr_en && !in_range(bus.wr_addr);
        uninit_hit = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            r_ok[ch]   = in_range(raddr[ch]);
            r_idx[ch]  = r_ok[ch] ? raddr[ch][IDX_W-1:0] : '0;
            r_hit[ch]  = r_ok[ch] && written[ch][r_idx[ch]];
            r_data[ch] = r_hit[ch] ? mem[ch][r_idx[ch]] : '0;
            oob_hit    = oob_hit    | (req[ch] && !r_ok[ch]);
            uninit_hit = uninit_hit | (req[ch] && r_ok[ch] && !r_hit[ch]);
        end
    end

    // Array contents survive reset; only the written bits are cleared.
    always_ff @(posedge sys_clk) begin
        if (wr_ok) begin
            mem[bus.wr_sel][w_idx] <= bus.wr_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                vld_q[ch]   <= '0;
                cnt_q[ch]   <= '0;
                written[ch] <= '0;
                for (int k = 0; k < RD_LAT; k++) begin
                    dat_q[ch][k] <= '0;
                end
            end
            err_oob_q    <= 1'b0;
            err_uninit_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                vld_q[ch][0] <= req[ch];
                if (req[ch]) begin
                    dat_q[ch][0] <= r_data[ch];
                    cnt_q[ch]    <= cnt_q[ch] + 32'd1;
                end
                // Data stages load only behind a valid, so the last stage holds between pulses.
                for (int k = 1; k < RD_LAT; k++) begin
                    vld_q[ch][k] <= vld_q[ch][k-1];
                    if (vld_q[ch][k-1]) begin
                        dat_q[ch][k] <= dat_q[ch][k-1];
                    end
                end
            end
            if (wr_ok) begin
                written[bus.wr_sel][w_idx] <= 1'b1;
            end
            err_oob_q    <= err_oob_q | oob_hit;
            err_uninit_q <= err_uninit_q | uninit_hit;
        end
    end

    assign bus.rd_valid_a = vld_q[0][RD_LAT-1];
    assign bus.rd_valid_b = vld_q[1][RD_LAT-1];
    assign bus.rd_data_a  = dat_q[0][RD_LAT-1];
    assign bus.rd_data_b  = dat_q[1][RD_LAT-1];
    assign bus.rd_cnt_a   = cnt_q[0];
    assign bus.rd_cnt_b   = cnt_q[1];
    assign bus.err_oob    = err_oob_q;
    assign bus.err_uninit = err_uninit_q;
endmodule

// File: tb/tb_hls_array_server.sv
// tb/tb_hls_array_server.sv - four parameter variants driven in lockstep against a queue-based model
module tb_hls_array_server;
    localparam int NI = 4;
    localparam int LAT_T [NI] = '{2, 2, 1, 4};
    localparam int DEP_T [NI] = '{256, 128, 256, 256};

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        wr_en, wr_sel, rd_req_a, rd_req_b;
    logic [7:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_data;

    logic        obs_vld [NI][2];
    logic [31:0] obs_dat [NI][2];
    logic [31:0] obs_cnt [NI][2];
    logic        obs_oob [NI];
    logic        obs_un  [NI];

    always #5 sys_clk = ~sys_clk;

    genvar g;
    for (g = 0; g < NI; g++) begin : gi
        hls_array_server_if #(.DATA_W(32), .ADDR_W(8)) bus ();
        assign bus.wr_en     = wr_en;
        assign bus.wr_sel    = wr_sel;
        assign bus.wr_addr   = wr_addr;
        assign bus.wr_data   = wr_data;
        assign bus.rd_req_a  = rd_req_a;
        assign bus.rd_req_b  = rd_req_b;
        assign bus.rd_addr_a = rd_addr_a;
        assign bus.rd_addr_b = rd_addr_b;
        hls_array_server #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEP_T[g]), .RD_LAT(LAT_T[g])) dut (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .bus     (bus.slave)
        );
        assign obs_vld[g][0] = bus.rd_valid_a;
        assign obs_vld[g][1] = bus.rd_valid_b;
        assign obs_dat[g][0] = bus.rd_data_a;
        assign obs_dat[g][1] = bus.rd_data_b;
        assign obs_cnt[g][0] = bus.rd_cnt_a;
        assign obs_cnt[g][1] = bus.rd_cnt_b;
        assign obs_oob[g]    = bus.err_oob;
        assign obs_un[g]     = bus.err_uninit;
    end

    typedef struct {
        int          due;
        int          inst;
        int          ch;
        logic [31:0] data;
    } exp_t;

    logic [31:0] m_mem  [NI][2][256];
    bit          m_wr   [NI][2][256];
    bit          m_oob  [NI];
    bit          m_un   [NI];
    int unsigned m_cnt  [NI][2];
    logic [31:0] m_last [NI][2];
    exp_t        pend [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        for (int i = 0; i < NI; i++) begin
            m_oob[i] = 0;
            m_un[i]  = 0;
            for (int ch = 0; ch < 2; ch++) begin
                m_cnt[i][ch]  = 0;
                m_last[i][ch] = '0;
                for (int a = 0; a < 256; a++) m_wr[i][ch][a] = 0;
            end
        end
    endtask

    // Reads see the store as it was before this edge's write.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                logic        rq;
                int          ad;
                logic [31:0] d;
                rq = ch ? rd_req_b : rd_req_a;
                ad = ch ? int'(rd_addr_b) : int'(rd_addr_a);
                if (rq) begin
                    m_cnt[i][ch]++;
                    d = '0;
                    if (ad >= DEP_T[i]) m_oob[i] = 1;
                    else if (!m_wr[i][ch][ad]) m_un[i] = 1;
                    else d = m_mem[i][ch][ad];
                    pend.push_back('{cyc + LAT_T[i] - 1, i, ch, d});
                end
            end
            if (wr_en) begin
                if (int'(wr_addr) >= DEP_T[i]) m_oob[i] = 1;
                else begin
                    m_mem[i][int'(wr_sel)][wr_addr] = wr_data;
                    m_wr[i][int'(wr_sel)][wr_addr]  = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                logic ev;
                ev = 1'b0;
                for (int k = pend.size() - 1; k >= 0; k--) begin
                    if (pend[k].due == cyc && pend[k].inst == i && pend[k].ch == ch) begin
                        ev = 1'b1;
                        m_last[i][ch] = pend[k].data;
                        pend.delete(k);
                    end
                end
                check($sformatf("rd_valid[%0d]", ch), i, 32'(obs_vld[i][ch]), 32'(ev));
                check($sformatf("rd_data[%0d]", ch), i, obs_dat[i][ch], m_last[i][ch]);
                check($sformatf("rd_cnt[%0d]", ch), i, obs_cnt[i][ch], m_cnt[i][ch]);
            end
            check("err_oob", i, 32'(obs_oob[i]), 32'(m_oob[i]));
            check("err_uninit", i, 32'(obs_un[i]), 32'(m_un[i]));
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        cyc++;
        if (!sys_rst) model_edge();
        #1;
        check_all();
        @(negedge sys_clk);
    endtask

    task automatic idle();
        wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0;
        rd_req_a = 0; rd_req_b = 0; rd_addr_a = '0; rd_addr_b = '0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        #1;
        model_clear();
        check_all();
        tick();
        sys_rst = 1'b0;
    endtask

    initial begin
        idle();
        model_clear();
        @(negedge sys_clk);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_sel = 0; wr_addr = 8'(i); wr_data = 32'(i + 1);
            tick();
            wr_sel = 1; wr_data = 32'(2 * (i + 1));
            tick();
        end
        idle();

        rd_req_a = 1; rd_addr_a = 8'd3; rd_req_b = 1; rd_addr_b = 8'd3;
        tick();
        idle();
        check("lat1_valid_a", 2, 32'(obs_vld[2][0]), 32'd1);
        check("lat1_data_a", 2, obs_dat[2][0], 32'd4);
        check("lat2_early", 0, 32'(obs_vld[0][0]), 32'd0);
        tick();
        check("lat2_data_a", 0, obs_dat[0][0], 32'd4);
        check("lat2_data_b", 0, obs_dat[0][1], 32'd8);
        check("lat4_early", 3, 32'(obs_vld[3][1]), 32'd0);
        tick();
        tick();
        check("lat4_valid_b", 3, 32'(obs_vld[3][1]), 32'd1);
        check("lat4_data_b", 3, obs_dat[3][1], 32'd8);
        tick();

        for (int i = 0; i < 8; i++) begin
            rd_req_a = 1; rd_addr_a = 8'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 5; i++) tick();
        check("burst_cnt_a", 0, obs_cnt[0][0], 32'd9);
        check("burst_last_a", 0, obs_dat[0][0], 32'd8);

        wr_en = 1; wr_sel = 0; wr_addr = 8'd5; wr_data = 32'hDEAD;
        rd_req_a = 1; rd_addr_a = 8'd5;
        tick();
        idle();
        rd_req_a = 1; rd_addr_a = 8'd5;
        tick();
        idle();
        check("rbw_old", 0, obs_dat[0][0], 32'd6);
        tick();
        check("rbw_new", 0, obs_dat[0][0], 32'hDEAD);
        for (int i = 0; i < 4; i++) tick();

        rd_req_a = 1; rd_addr_a = 8'd200;
        tick();
        idle();
        for (int i = 0; i < 5; i++) tick();
        check("a200_uninit_d256", 0, 32'(obs_un[0]), 32'd1);
        check("a200_oob_d256", 0, 32'(obs_oob[0]), 32'd0);
        check("a200_oob_d128", 1, 32'(obs_oob[1]), 32'd1);
        check("a200_uninit_d128", 1, 32'(obs_un[1]), 32'd0);
        check("a200_data", 0, obs_dat[0][0], 32'd0);

        rd_req_a = 1; rd_addr_a = 8'd1;
        tick();
        idle();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check("rst_no_pulse_data", 3, obs_dat[3][0], 32'd0);
        rd_req_a = 1; rd_addr_a = 8'd1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        check("rst_written_cleared", 0, 32'(obs_un[0]), 32'd1);
        check("rst_read_zero", 0, obs_dat[0][0], 32'd0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) == 0) begin
                idle();
                do_reset();
            end
            wr_en     = 1'($urandom_range(1));
            wr_sel    = 1'($urandom_range(1));
            wr_addr   = ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(15));
            wr_data   = $urandom;
            rd_req_a  = 1'($urandom_range(1));
            rd_req_b  = 1'($urandom_range(1));
            rd_addr_a = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(15));
            rd_addr_b = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(15));
            tick();
        end
        idle();
        for (int i = 0; i < 6; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
